mini_cpu_loader: RTL

Upstream feeder for the mini CPU core.
- Accepts a program as a byte stream over a valid/ready handshake.
- Writes the bytes into the CPU's 16x8 memory through a write port, then zero-fills any unwritten words so leftover words decode as NOP.
- Releases the CPU by generating a fixed number of `step` pulses (the CPU's clock), then reports done.

---
 rtl/mini_cpu_pkg.sv | 31 +++
 rtl/mini_cpu_loader_if.sv | 29 ++
 rtl/mini_cpu_step_gen.sv | 56 +++++
 rtl/mini_cpu_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mini_cpu_pkg                                                               |
// | Loader FSM states, memory depth and opcode constants for the mini CPU.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mini_cpu_pkg;

  localparam int MEM_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    DRAIN = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Opcode layout: {op[1:0], reg, addr[4:0]}; an all-zero word decodes as NOP.
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam int         OP_REG_BIT = 5;
  localparam int         OP_ADDR_W  = 5;

  function automatic logic [7:0] op_load(input logic rsel, input logic [OP_ADDR_W-1:0] a);
    return {OP_LOAD, rsel, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mini_cpu_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mini_cpu_loader_if                                                         |
// | Program byte stream (valid/ready/last) plus the memory write port.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mini_cpu_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mini_cpu_step_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mini_cpu_step_gen                                                          |
// | Emits count cpu_step pulses, STEP_HALF clk low then STEP_HALF clk high.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mini_cpu_step_gen #(
  parameter int STEP_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] count,
  input  logic       en,
  output logic       cpu_step,
  output logic       busy,
  output logic       fin
);
  localparam int c_ph_w = (STEP_HALF > 1) ? $clog2(STEP_HALF) : 1;
  localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(STEP_HALF - 1);

  logic [7:0]        r_cnt;
  logic [c_ph_w-1:0] r_ph;
  logic              r_high;
  logic              w_ph_end;

  assign w_ph_end = (r_ph == c_ph_last);

  // The count drops on the high-to-low transition, so a pulse is only
  // retired once its high half has been fully emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 8'd0;
      r_ph   <= '0;
      r_high <= 1'b0;
    end else if (start) begin
      r_cnt  <= count;
      r_ph   <= '0;
      r_high <= 1'b0;
    end else if (en && (r_cnt != 8'd0)) begin
      if (w_ph_end) begin
        r_ph   <= '0;
        r_high <= ~r_high;
        if (r_high) r_cnt <= r_cnt - 8'd1;
      end else begin
        r_ph <= r_ph + c_ph_w'(1);
      end
    end
  end

  assign cpu_step = r_high;
  assign busy     = (r_cnt != 8'd0);
  assign fin      = en && r_high && w_ph_end && (r_cnt == 8'd1);

endmodule
`default_nettype wire

// File: rtl/mini_cpu_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mini_cpu_loader                                                            |
// | Streams a program into CPU memory, zero-fills the rest, then steps the     |
// | CPU. Define LOADER_CHECKSUM_EN to treat the last byte as a checksum.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mini_cpu_loader
  import mini_cpu_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int STEP_HALF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mini_cpu_loader_if.slave bus,
  input  logic [7:0]       run_steps,
  output logic             cpu_step,
  output logic             busy,
  output logic             done,
  output logic             overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic             chk_err
`endif
);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'((2 ** ADDR_W) - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_overflow;
  logic              w_in_ready, w_xfer, w_first, w_run;
  logic              w_we, w_clear_wr, w_start, w_addr_inc, w_addr_clr, w_set_ovf;
  logic              w_step_busy, w_step_fin;

  assign w_in_ready = (r_state == IDLE) || (r_state == LOAD) ||
                      (r_state == DRAIN) || (r_state == DONE);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_first    = w_xfer && ((r_state == IDLE) || (r_state == DONE));
  assign w_run      = (r_state == RUN);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum, w_sum_cur;
  logic              r_chk_err, w_ok;

  assign w_sum_cur = w_first ? {DATA_W{1'b0}} : r_sum;
  assign w_ok      = (bus.in_data == w_sum_cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= {DATA_W{1'b0}};
      r_chk_err <= 1'b0;
    end else begin
      if (w_we && !w_clear_wr) r_sum <= w_sum_cur + bus.in_data;
      if (w_xfer && bus.in_last && !w_ok) r_chk_err <= 1'b1;
      else if (w_first) r_chk_err <= 1'b0;
    end
  end

  assign chk_err = r_chk_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_clear_wr  = 1'b0;
    w_start     = 1'b0;
    w_addr_inc  = 1'b0;
    w_addr_clr  = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      IDLE, LOAD, DONE: begin
        if (w_xfer) begin
          w_we = 1'b1;
          if (bus.in_last) begin
            w_start = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            // Checksum byte is not stored; zero-fill starts at its address.
            w_we        = 1'b0;
            w_state_nxt = CLEAR;
`else
            if (r_addr == c_last_addr) begin
              w_addr_clr  = 1'b1;
              w_state_nxt = (run_steps != 8'd0) ? RUN : DONE;
            end else begin
              w_addr_inc  = 1'b1;
              w_state_nxt = CLEAR;
            end
`endif
          end else if (r_addr == c_last_addr) begin
            w_addr_clr  = 1'b1;
            w_set_ovf   = 1'b1;
            w_state_nxt = DRAIN;
          end else begin
            w_addr_inc  = 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      DRAIN: begin
        if (w_xfer && bus.in_last) begin
          w_start     = 1'b1;
          w_state_nxt = (run_steps != 8'd0) ? RUN : DONE;
`ifdef LOADER_CHECKSUM_EN
          if (!w_ok) w_state_nxt = DONE;
`endif
        end
      end
      CLEAR: begin
        w_we       = 1'b1;
        w_clear_wr = 1'b1;
        if (r_addr == c_last_addr) begin
          w_addr_clr  = 1'b1;
          w_state_nxt = w_step_busy ? RUN : DONE;
`ifdef LOADER_CHECKSUM_EN
          if (r_chk_err) w_state_nxt = DONE;
`endif
        end else begin
          w_addr_inc = 1'b1;
        end
      end
      RUN: begin
        if (w_step_fin) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Address returns to 0 on leaving the load phase so DONE restarts like IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_addr_clr)      r_addr <= '0;
      else if (w_addr_inc) r_addr <= r_addr + ADDR_W'(1);
      if (w_set_ovf)       r_overflow <= 1'b1;
      else if (w_first)    r_overflow <= 1'b0;
    end
  end

  mini_cpu_step_gen #(
    .STEP_HALF (STEP_HALF)
  ) u_step_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .count    (run_steps),
    .en       (w_run),
    .cpu_step (cpu_step),
    .busy     (w_step_busy),
    .fin      (w_step_fin)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = (w_we && !w_clear_wr) ? bus.in_data : {DATA_W{1'b0}};
  assign busy          = (r_state != IDLE) && (r_state != DONE);
  assign done          = (r_state == DONE);
  assign overflow      = r_overflow;

endmodule
`default_nettype wire
